// File: rtl/pdp8_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : pdp8_mem_responder
// Purpose  : Single-ported 4096x12 PDP-8 main memory. It serves three
//            requesters: instruction fetch (IFU read), execution-unit data
//            read, and execution-unit data write. It also provides a backdoor
//            load port. The array performs one access per cycle. Requests
//            that lose arbitration wait in a one-deep pending slot per class.
// Ports    : clk, reset_n             - clock, synchronous active-low reset
//            ifu_rd_req/addr          - fetch read request and address
//            ifu_rd_data/valid        - fetch return word and strobe
//            exu_rd_req/addr          - data read request and address
//            exu_rd_data/valid        - data read return word and strobe
//            exu_wr_req/addr/data     - data write request
//            load_en/addr/data        - backdoor write (highest priority)
//            busy                     - any pending slot occupied
//            proto_err                - sticky protocol violation
// Revision : 1.0 - initial release
// ============================================================================
module pdp8_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,

    input  logic                  exu_rd_req,
    input  logic [ADDR_WIDTH-1:0] exu_rd_addr,
    output logic [DATA_WIDTH-1:0] exu_rd_data,
    output logic                  exu_rd_valid,

    input  logic                  exu_wr_req,
    input  logic [ADDR_WIDTH-1:0] exu_wr_addr,
    input  logic [DATA_WIDTH-1:0] exu_wr_data,

    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,

    output logic                  busy,
    output logic                  proto_err
);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Pending slots
    logic                  r_wr_pend_vld;
    logic [ADDR_WIDTH-1:0] r_wr_pend_addr;
    logic [DATA_WIDTH-1:0] r_wr_pend_data;
    logic                  r_exu_pend_vld;
    logic [ADDR_WIDTH-1:0] r_exu_pend_addr;
    logic                  r_ifu_pend_vld;
    logic [ADDR_WIDTH-1:0] r_ifu_pend_addr;

    // Registered outputs
    logic [DATA_WIDTH-1:0] r_ifu_rd_data;
    logic                  r_ifu_rd_valid;
    logic [DATA_WIDTH-1:0] r_exu_rd_data;
    logic                  r_exu_rd_valid;
    logic                  r_busy;
    logic                  r_proto_err;

    // ------------------------------------------------------------------------
    // Candidates. An occupied slot always wins over a new request of the
    // same class. A new request that arrives while its slot is occupied is
    // illegal. It is dropped and flagged below.
    // ------------------------------------------------------------------------
    logic                  w_wr_cand_vld;
    logic [ADDR_WIDTH-1:0] w_wr_cand_addr;
    logic [DATA_WIDTH-1:0] w_wr_cand_data;
    logic                  w_exu_cand_vld;
    logic [ADDR_WIDTH-1:0] w_exu_cand_addr;
    logic                  w_ifu_cand_vld;
    logic [ADDR_WIDTH-1:0] w_ifu_cand_addr;

    assign w_wr_cand_vld   = r_wr_pend_vld | exu_wr_req;
    assign w_wr_cand_addr  = r_wr_pend_vld ? r_wr_pend_addr : exu_wr_addr;
    assign w_wr_cand_data  = r_wr_pend_vld ? r_wr_pend_data : exu_wr_data;
    assign w_exu_cand_vld  = r_exu_pend_vld | exu_rd_req;
    assign w_exu_cand_addr = r_exu_pend_vld ? r_exu_pend_addr : exu_rd_addr;
    assign w_ifu_cand_vld  = r_ifu_pend_vld | ifu_rd_req;
    assign w_ifu_cand_addr = r_ifu_pend_vld ? r_ifu_pend_addr : ifu_rd_addr;

    // ------------------------------------------------------------------------
    // Fixed-priority grant: load > write > exu read > ifu read.
    // Writes rank above reads. As a result, a read queued in the same cycle
    // as a write, or behind a write, sees the post-write contents.
    // ------------------------------------------------------------------------
    logic w_gnt_load;
    logic w_gnt_wr;
    logic w_gnt_exu;
    logic w_gnt_ifu;

    assign w_gnt_load = load_en;
    assign w_gnt_wr   = !load_en && w_wr_cand_vld;
    assign w_gnt_exu  = !load_en && !w_wr_cand_vld && w_exu_cand_vld;
    assign w_gnt_ifu  = !load_en && !w_wr_cand_vld && !w_exu_cand_vld
                        && w_ifu_cand_vld;

    // Single array port: one shared address for the granted access
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    always_comb begin
        w_mem_addr = w_ifu_cand_addr;
        if (w_gnt_load) begin
            w_mem_addr = load_addr;
        end else if (w_gnt_wr) begin
            w_mem_addr = w_wr_cand_addr;
        end else if (w_gnt_exu) begin
            w_mem_addr = w_exu_cand_addr;
        end
    end

    assign w_mem_wdata = load_en ? load_data : w_wr_cand_data;
    // A write granted during the reset cycle is cancelled
    assign w_mem_we    = reset_n && (w_gnt_load || w_gnt_wr);
    assign w_mem_rdata = r_mem[w_mem_addr];

    // ------------------------------------------------------------------------
    // Slot next-state. An occupied slot frees when its entry is granted. An
    // empty slot captures a new request that was not granted this cycle.
    // ------------------------------------------------------------------------
    logic w_wr_fill;
    logic w_exu_fill;
    logic w_ifu_fill;
    logic w_wr_pend_nxt;
    logic w_exu_pend_nxt;
    logic w_ifu_pend_nxt;
    logic w_err;

    assign w_wr_fill  = !r_wr_pend_vld  && exu_wr_req && !w_gnt_wr;
    assign w_exu_fill = !r_exu_pend_vld && exu_rd_req && !w_gnt_exu;
    assign w_ifu_fill = !r_ifu_pend_vld && ifu_rd_req && !w_gnt_ifu;

    assign w_wr_pend_nxt  = r_wr_pend_vld  ? !w_gnt_wr  : w_wr_fill;
    assign w_exu_pend_nxt = r_exu_pend_vld ? !w_gnt_exu : w_exu_fill;
    assign w_ifu_pend_nxt = r_ifu_pend_vld ? !w_gnt_ifu : w_ifu_fill;

    // A granted read returns its data on the cycle right after the grant.
    // So a read is outstanding exactly while it sits in its slot. A new
    // request of the same class in that window is a violation.
    assign w_err = (exu_wr_req && r_wr_pend_vld)
                 | (exu_rd_req && r_exu_pend_vld)
                 | (ifu_rd_req && r_ifu_pend_vld);

    // ------------------------------------------------------------------------
    // Array. Contents are not reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Control, slots and registered returns
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_pend_vld   <= 1'b0;
            r_wr_pend_addr  <= '0;
            r_wr_pend_data  <= '0;
            r_exu_pend_vld  <= 1'b0;
            r_exu_pend_addr <= '0;
            r_ifu_pend_vld  <= 1'b0;
            r_ifu_pend_addr <= '0;
            r_ifu_rd_data   <= '0;
            r_ifu_rd_valid  <= 1'b0;
            r_exu_rd_data   <= '0;
            r_exu_rd_valid  <= 1'b0;
            r_busy          <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            r_wr_pend_vld  <= w_wr_pend_nxt;
            r_exu_pend_vld <= w_exu_pend_nxt;
            r_ifu_pend_vld <= w_ifu_pend_nxt;

            if (w_wr_fill) begin
                r_wr_pend_addr <= exu_wr_addr;
                r_wr_pend_data <= exu_wr_data;
            end
            if (w_exu_fill) begin
                r_exu_pend_addr <= exu_rd_addr;
            end
            if (w_ifu_fill) begin
                r_ifu_pend_addr <= ifu_rd_addr;
            end

            // Data registers hold their value between strobes
            r_ifu_rd_valid <= w_gnt_ifu;
            r_exu_rd_valid <= w_gnt_exu;
            if (w_gnt_ifu) begin
                r_ifu_rd_data <= w_mem_rdata;
            end
            if (w_gnt_exu) begin
                r_exu_rd_data <= w_mem_rdata;
            end

            r_busy      <= w_wr_pend_nxt | w_exu_pend_nxt | w_ifu_pend_nxt;
            r_proto_err <= r_proto_err | w_err;
        end
    end

    assign ifu_rd_data  = r_ifu_rd_data;
    assign ifu_rd_valid = r_ifu_rd_valid;
    assign exu_rd_data  = r_exu_rd_data;
    assign exu_rd_valid = r_exu_rd_valid;
    assign busy         = r_busy;
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_pdp8_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdp8_mem_responder
// Purpose  : Self-checking directed bench for pdp8_mem_responder. Expected
//            read returns are queued, together with their due cycle, when a
//            request is driven. They are popped when the matching strobe
//            fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdp8_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic [11:0] ifu_rd_data;
    logic        ifu_rd_valid;
    logic        exu_rd_req;
    logic [11:0] exu_rd_addr;
    logic [11:0] exu_rd_data;
    logic        exu_rd_valid;
    logic        exu_wr_req;
    logic [11:0] exu_wr_addr;
    logic [11:0] exu_wr_data;
    logic        load_en;
    logic [11:0] load_addr;
    logic [11:0] load_data;
    logic        busy;
    logic        proto_err;

    pdp8_mem_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ifu_rd_req   (ifu_rd_req),
        .ifu_rd_addr  (ifu_rd_addr),
        .ifu_rd_data  (ifu_rd_data),
        .ifu_rd_valid (ifu_rd_valid),
        .exu_rd_req   (exu_rd_req),
        .exu_rd_addr  (exu_rd_addr),
        .exu_rd_data  (exu_rd_data),
        .exu_rd_valid (exu_rd_valid),
        .exu_wr_req   (exu_wr_req),
        .exu_wr_addr  (exu_wr_addr),
        .exu_wr_data  (exu_wr_data),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;

    exp_t ifu_q[$];
    exp_t exu_q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe must match the oldest expectation in data
    // and cycle. A strobe with nothing queued is a stray valid.
    always @(negedge clk) begin
        if (ifu_rd_valid === 1'b1) begin
            check("ifu_expected_pending", ifu_q.size() > 0, 1);
            if (ifu_q.size() > 0) begin
                exp_t e;
                e = ifu_q.pop_front();
                check("ifu_data", ifu_rd_data, e.data);
                check("ifu_cycle", cyc, e.due);
            end
        end
        if (exu_rd_valid === 1'b1) begin
            check("exu_expected_pending", exu_q.size() > 0, 1);
            if (exu_q.size() > 0) begin
                exp_t e;
                e = exu_q.pop_front();
                check("exu_data", exu_rd_data, e.data);
                check("exu_cycle", cyc, e.due);
            end
        end
    end

    task automatic load_word(input logic [11:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (ifu_q.size() == 0 && exu_q.size() == 0) break;
            tick();
        end
        check(tag, ifu_q.size() + exu_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ifu_data"},  ifu_rd_data,  12'o0);
        check({tag, "_exu_data"},  exu_rd_data,  12'o0);
        check({tag, "_ifu_valid"}, ifu_rd_valid, 1'b0);
        check({tag, "_exu_valid"}, exu_rd_valid, 1'b0);
        check({tag, "_busy"},      busy,         1'b0);
        check({tag, "_proto_err"}, proto_err,    1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset_n = 1'b0;
        ifu_rd_req = 1'b0; ifu_rd_addr = '0;
        exu_rd_req = 1'b0; exu_rd_addr = '0;
        exu_wr_req = 1'b0; exu_wr_addr = '0; exu_wr_data = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Program image
        load_word(12'o0200, 12'o1234);
        load_word(12'o0201, 12'o7402);
        load_word(12'o0300, 12'o0111);
        load_word(12'o0301, 12'o0042);
        load_word(12'o0010, 12'o3333);
        load_word(12'o0400, 12'o1111);
        load_word(12'o7777, 12'o7070);
        load_word(12'o0000, 12'o0707);
        tick();

        // Two fetches, each issued after the previous valid
        k = cyc;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
        ifu_q.push_back('{data: 12'o1234, due: k + 1});
        tick();
        ifu_rd_req = 1'b0;
        drain("drain_fetch0200");
        k = cyc;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0201;
        ifu_q.push_back('{data: 12'o7402, due: k + 1});
        tick();
        ifu_rd_req = 1'b0;
        drain("drain_fetch0201");
        check("fetch_proto_err", proto_err, 1'b0);

        // Write, exu read and ifu read in one cycle
        k = cyc;
        exu_wr_req = 1'b1; exu_wr_addr = 12'o0300; exu_wr_data = 12'o5555;
        exu_rd_req = 1'b1; exu_rd_addr = 12'o0301;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0300;
        exu_q.push_back('{data: 12'o0042, due: k + 2});
        ifu_q.push_back('{data: 12'o5555, due: k + 3});
        tick();
        exu_wr_req = 1'b0; exu_rd_req = 1'b0; ifu_rd_req = 1'b0;
        check("conflict_busy_c1", busy, 1'b1);
        tick();
        check("conflict_busy_c2", busy, 1'b1);
        tick();
        check("conflict_busy_c3", busy, 1'b0);
        drain("drain_conflict");
        check("conflict_proto_err", proto_err, 1'b0);

        // Fetch stalled behind three cycles of backdoor loads
        k = cyc;
        load_en = 1'b1; load_addr = 12'o0500; load_data = 12'o2222;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0010;
        ifu_q.push_back('{data: 12'o3333, due: k + 4});
        tick();
        ifu_rd_req = 1'b0;
        load_addr = 12'o0501; load_data = 12'o2223;
        tick();
        load_addr = 12'o0502; load_data = 12'o2224;
        tick();
        load_en = 1'b0;
        drain("drain_load_stall");
        check("load_stall_proto_err", proto_err, 1'b0);

        // exu read wins over a same-cycle fetch; the ifu data holds meanwhile
        k = cyc;
        exu_rd_req = 1'b1; exu_rd_addr = 12'o0502;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0201;
        exu_q.push_back('{data: 12'o2224, due: k + 1});
        ifu_q.push_back('{data: 12'o7402, due: k + 2});
        tick();
        exu_rd_req = 1'b0; ifu_rd_req = 1'b0;
        check("ifu_data_hold", ifu_rd_data, 12'o3333);
        drain("drain_exu_first");

        // Illegal second fetch while the first waits behind a write
        k = cyc;
        exu_wr_req = 1'b1; exu_wr_addr = 12'o0600; exu_wr_data = 12'o4444;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0600;
        ifu_q.push_back('{data: 12'o4444, due: k + 2});
        tick();
        exu_wr_req = 1'b0;
        ifu_rd_addr = 12'o0200;
        tick();
        ifu_rd_req = 1'b0;
        check("proto_err_set", proto_err, 1'b1);
        repeat (4) tick();
        check("proto_err_sticky", proto_err, 1'b1);
        drain("drain_second_fetch");

        // Reset while a write and a fetch are pending behind a load
        load_en = 1'b1; load_addr = 12'o0700; load_data = 12'o1000;
        exu_wr_req = 1'b1; exu_wr_addr = 12'o0400; exu_wr_data = 12'o6666;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0010;
        tick();
        load_en = 1'b0; exu_wr_req = 1'b0; ifu_rd_req = 1'b0;
        check("pre_reset_busy", busy, 1'b1);
        reset_n = 1'b0;
        tick();
        check_reset_values("midreset");
        reset_n = 1'b1;
        repeat (3) tick();
        k = cyc;
        exu_rd_req = 1'b1; exu_rd_addr = 12'o0700;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0400;
        exu_q.push_back('{data: 12'o1000, due: k + 1});
        ifu_q.push_back('{data: 12'o1111, due: k + 2});
        tick();
        exu_rd_req = 1'b0; ifu_rd_req = 1'b0;
        drain("drain_after_reset");

        // Back-to-back fetches at the top and bottom of memory
        k = cyc;
        ifu_rd_req = 1'b1; ifu_rd_addr = 12'o7777;
        ifu_q.push_back('{data: 12'o7070, due: k + 1});
        tick();
        ifu_rd_addr = 12'o0000;
        ifu_q.push_back('{data: 12'o0707, due: k + 2});
        tick();
        ifu_rd_req = 1'b0;
        drain("drain_edges");
        repeat (3) tick();
        check("final_proto_err", proto_err, 1'b0);
        check("final_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
